// File: rtl/tid_pkg.sv
// Shared types and default sizes for the thread-ID table and its loader.
package tid_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int TID_DATA_WIDTH = 32;
    localparam int TID_ADDR_WIDTH = 10;

endpackage

// File: rtl/tid_table_loader.sv
// Fills the thread-ID table with base_id + i*stride, one entry per cycle.
module tid_table_loader
    import tid_pkg::*;
#(
    parameter int DATA_WIDTH = TID_DATA_WIDTH,
    parameter int ADDR_WIDTH = TID_ADDR_WIDTH,
    parameter int ADDR_DEPTH = 1 << ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] base_id,
    input  logic [DATA_WIDTH-1:0] stride,
    input  logic [ADDR_WIDTH:0]   count,
    input  logic                  abort,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wa,
    output logic [DATA_WIDTH-1:0] di
);

    localparam logic [ADDR_WIDTH:0]   DEPTH_C = (ADDR_WIDTH+1)'(ADDR_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ONE_A   = ADDR_WIDTH'(1);

    state_t state_q, state_d;

    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] wa_q, wa_d;
    logic [DATA_WIDTH-1:0] di_q, di_d;
    logic [DATA_WIDTH-1:0] stride_q, stride_d;
    logic [ADDR_WIDTH-1:0] last_q, last_d;

    logic                  cnt_zero;
    logic                  cnt_over;
    logic                  at_last;
    logic [ADDR_WIDTH-1:0] last_n;

    // Oversized requests clamp to the full table, so the last index is all ones.
    assign cnt_zero = (count == '0);
    assign cnt_over = (count > DEPTH_C);
    assign last_n   = (count >= DEPTH_C) ? '1
                                         : count[ADDR_WIDTH-1:0] - ONE_A;
    assign at_last  = (wa_q == last_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = cnt_zero ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (at_last) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy_d   = 1'b0;
        done_d   = 1'b0;
        we_d     = 1'b0;
        err_d    = err_q;
        wa_d     = wa_q;
        di_d     = di_q;
        stride_d = stride_q;
        last_d   = last_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    err_d    = cnt_over;
                    stride_d = stride;
                    last_d   = last_n;
                    if (cnt_zero) begin
                        done_d = 1'b1;
                    end else begin
                        we_d   = 1'b1;
                        busy_d = 1'b1;
                        wa_d   = '0;
                        di_d   = base_id;
                    end
                end
            end
            WRITE: begin
                // Abort outranks completion: no done pulse after an abort.
                if (abort) begin
                    done_d = 1'b0;
                end else if (at_last) begin
                    done_d = 1'b1;
                end else begin
                    we_d   = 1'b1;
                    busy_d = 1'b1;
                    wa_d   = wa_q + ONE_A;
                    di_d   = di_q + stride_q;
                end
            end
            DONE:    done_d = 1'b0;
            default: done_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            we_q     <= 1'b0;
            wa_q     <= '0;
            di_q     <= '0;
            stride_q <= '0;
            last_q   <= '0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            we_q     <= we_d;
            wa_q     <= wa_d;
            di_q     <= di_d;
            stride_q <= stride_d;
            last_q   <= last_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign err  = err_q;
    assign we   = we_q;
    assign wa   = wa_q;
    assign di   = di_q;

endmodule

// File: tb/tb_tid_table_loader.sv
// Scoreboard bench for tid_table_loader: expected writes queued at launch.
module tb_tid_table_loader;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_id;
    logic [31:0] stride;
    logic [10:0] count;
    logic        abort;
    logic        busy;
    logic        done;
    logic        err;
    logic        we;
    logic [9:0]  wa;
    logic [31:0] di;

    int checks;
    int failures;

    logic [41:0] exp_q[$];

    tid_table_loader dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .base_id(base_id),
        .stride (stride),
        .count  (count),
        .abort  (abort),
        .busy   (busy),
        .done   (done),
        .err    (err),
        .we     (we),
        .wa     (wa),
        .di     (di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every table write is popped against the queued model entry.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            logic [41:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL write_unexpected got wa=%0d di=%h want none",
                         wa, di);
            end else begin
                e = exp_q.pop_front();
                if ({wa, di} !== e) begin
                    failures++;
                    $display("FAIL write_data got wa=%0d di=%h want wa=%0d di=%h",
                             wa, di, e[41:32], e[31:0]);
                end
            end
        end
    end

    function automatic void push_exp(input logic [31:0] b,
                                     input logic [31:0] s,
                                     input int n);
        logic [31:0] d;
        d = b;
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({10'(i), d});
            d = d + s;
        end
    endfunction

    task automatic do_start(input logic [31:0] b, input logic [31:0] s,
                            input logic [10:0] c);
        @(posedge clk);
        #1;
        base_id = b;
        stride  = s;
        count   = c;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start   = 1'b0;
        base_id = 32'hDEAD_BEEF;
        stride  = 32'h1234_5678;
        count   = 11'd5;
    endtask

    task automatic observe(input int ncyc, output int done_at,
                           output int done_cnt, output int busy_cnt,
                           output int busy_first, output int we_cnt,
                           output logic [9:0] last_wa);
        done_at = -1;
        done_cnt = 0;
        busy_cnt = 0;
        busy_first = -1;
        we_cnt = 0;
        last_wa = '0;
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end
            if (busy === 1'b1) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = k;
            end
            if (we === 1'b1) begin
                we_cnt++;
                last_wa = wa;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, done, err, we, wa, di} !== 46'd0) begin
            failures++;
            $display("FAIL reset_outputs got b=%b d=%b e=%b w=%b wa=%0d di=%h want zeros",
                     busy, done, err, we, wa, di);
        end
    endtask

    task automatic test_basic();
        int da, dc, bc, bf, wc;
        logic [9:0] lw;
        push_exp(32'd100, 32'd1, 4);
        do_start(32'd100, 32'd1, 11'd4);
        observe(10, da, dc, bc, bf, wc, lw);
        checks++;
        if (da !== 4 || dc !== 1) begin
            failures++;
            $display("FAIL basic_done got at=%0d cnt=%0d want at=4 cnt=1", da, dc);
        end
        checks++;
        if (bc !== 4 || bf !== 0) begin
            failures++;
            $display("FAIL basic_busy got cnt=%0d first=%0d want 4/0", bc, bf);
        end
        checks++;
        if (wc !== 4 || err !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL basic_writes got we=%0d err=%b left=%0d want 4/0/0",
                     wc, err, exp_q.size());
        end
    endtask

    task automatic test_zero();
        int da, dc, bc, bf, wc;
        logic [9:0] lw;
        do_start(32'd55, 32'd2, 11'd0);
        observe(6, da, dc, bc, bf, wc, lw);
        checks++;
        if (wc !== 0 || bc !== 0) begin
            failures++;
            $display("FAIL zero_nowrite got we=%0d busy=%0d want 0/0", wc, bc);
        end
        checks++;
        if (da !== 0 || dc !== 1) begin
            failures++;
            $display("FAIL zero_done got at=%0d cnt=%0d want at=0 cnt=1", da, dc);
        end
    endtask

    task automatic test_wrap();
        int da, dc, bc, bf, wc;
        logic [9:0] lw;
        push_exp(32'd2, 32'hFFFF_FFFF, 4);
        do_start(32'd2, 32'hFFFF_FFFF, 11'd4);
        observe(8, da, dc, bc, bf, wc, lw);
        checks++;
        if (da !== 4 || wc !== 4 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL wrap_fill got done_at=%0d we=%0d left=%0d want 4/4/0",
                     da, wc, exp_q.size());
        end
    endtask

    task automatic test_overflow();
        int da, dc, bc, bf, wc;
        logic [9:0] lw;
        push_exp(32'h4000, 32'd3, 1024);
        do_start(32'h4000, 32'd3, 11'd1025);
        observe(1030, da, dc, bc, bf, wc, lw);
        checks++;
        if (err !== 1'b1) begin
            failures++;
            $display("FAIL ovf_err got %b want 1", err);
        end
        checks++;
        if (wc !== 1024 || lw !== 10'd1023 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL ovf_writes got we=%0d last=%0d left=%0d want 1024/1023/0",
                     wc, lw, exp_q.size());
        end
        checks++;
        if (da !== 1024 || bc !== 1024) begin
            failures++;
            $display("FAIL ovf_done got at=%0d busy=%0d want 1024/1024", da, bc);
        end
        push_exp(32'd7, 32'd9, 1);
        do_start(32'd7, 32'd9, 11'd1);
        observe(4, da, dc, bc, bf, wc, lw);
        checks++;
        if (err !== 1'b0 || da !== 1 || wc !== 1) begin
            failures++;
            $display("FAIL ovf_clear got err=%b done_at=%0d we=%0d want 0/1/1",
                     err, da, wc);
        end
    endtask

    task automatic test_abort();
        int wc, dc, bc;
        logic ok3;
        wc = 0;
        dc = 0;
        bc = 0;
        ok3 = 1'b0;
        push_exp(32'd50, 32'd3, 3);
        do_start(32'd50, 32'd3, 11'd8);
        start = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (we === 1'b1) wc++;
            if (done === 1'b1) dc++;
            if (busy === 1'b1) bc++;
            if (k == 3) ok3 = (we === 1'b0) && (busy === 1'b0);
            if (k == 2) abort = 1'b1;
            if (k == 3) begin
                abort = 1'b0;
                start = 1'b0;
            end
        end
        checks++;
        if (wc !== 3 || bc !== 3 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL abort_writes got we=%0d busy=%0d left=%0d want 3/3/0",
                     wc, bc, exp_q.size());
        end
        checks++;
        if (dc !== 0 || ok3 !== 1'b1) begin
            failures++;
            $display("FAIL abort_idle got done=%0d idle_at3=%b want 0/1", dc, ok3);
        end
    endtask

    task automatic test_reset_mid();
        int da, dc, bc, bf, wc;
        logic [9:0] lw;
        push_exp(32'd9, 32'd5, 2);
        do_start(32'd9, 32'd5, 11'd1025);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || busy !== 1'b1) begin
            failures++;
            $display("FAIL rstmid_pre got err=%b busy=%b want 1/1", err, busy);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if ({busy, done, err, we, wa, di} !== 46'd0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL rstmid_zero got b=%b d=%b e=%b w=%b wa=%0d di=%h left=%0d want zeros",
                     busy, done, err, we, wa, di, exp_q.size());
        end
        push_exp(32'd1000, 32'd7, 8);
        do_start(32'd1000, 32'd7, 11'd8);
        observe(12, da, dc, bc, bf, wc, lw);
        checks++;
        if (da !== 8 || wc !== 8 || lw !== 10'd7 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL rstmid_refill got done_at=%0d we=%0d last=%0d left=%0d want 8/8/7/0",
                     da, wc, lw, exp_q.size());
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        base_id = '0;
        stride = '0;
        count = '0;
        test_reset();
        test_basic();
        test_zero();
        test_wrap();
        test_overflow();
        test_abort();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
